// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner with double-buffered display data.
// Each digit slot is a blanking phase followed by a drive phase; new data is committed at frame end.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic [7:0]  digit_en_in,
  input  logic [7:0]  dp_in,
  input  logic        lz_in,
  input  logic        load,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        pending,
  output logic        ack,
  output logic        frame_tick,
  output logic        state_dbg
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic        slot_end, commit, suppress;
  logic [31:0] sh_val, disp_val, disp_val_n;
  logic [7:0]  sh_en, sh_dp, disp_en, disp_dp, disp_en_n, disp_dp_n;
  logic        sh_lz, disp_lz, disp_lz_n;
  logic [3:0]  nib;
  logic [7:0]  an_n, seg_n;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  assign state_dbg = (state == ST_DRIVE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CW'(1);
    idx_n    = idx;
    slot_end = (state == ST_DRIVE) && (cnt == LAST_CNT);
    case (state)
      ST_BLANK: if (cnt == BLANK_LAST) state_n = ST_DRIVE;
      ST_DRIVE: if (slot_end) begin
        state_n = ST_BLANK;
        cnt_n   = '0;
        idx_n   = idx + 3'd1;
      end
      default: state_n = ST_BLANK;
    endcase

    frame_tick = slot_end && (idx == 3'd7);
    ack        = frame_tick && pending;
    commit     = ack;

    disp_val_n = commit ? sh_val : disp_val;
    disp_en_n  = commit ? sh_en  : disp_en;
    disp_dp_n  = commit ? sh_dp  : disp_dp;
    disp_lz_n  = commit ? sh_lz  : disp_lz;

    // Outputs are registered from next-state values so an/seg line up with the FSM cycle.
    nib      = disp_val_n[{idx_n, 2'b00} +: 4];
    suppress = !disp_en_n[idx_n] ||
               (disp_lz_n && (idx_n != 3'd0) && ((disp_val_n >> {idx_n, 2'b00}) == 32'd0));
    an_n  = 8'hFF;
    seg_n = 8'hFF;
    if (state_n == ST_DRIVE) begin
      seg_n = {~disp_dp_n[idx_n], glyph(nib)};
      if (!suppress) an_n = ~(8'b1 << idx_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_BLANK;
      cnt      <= '0;
      idx      <= '0;
      pending  <= 1'b0;
      sh_val   <= '0;
      sh_en    <= 8'hFF;
      sh_dp    <= '0;
      sh_lz    <= 1'b0;
      disp_val <= '0;
      disp_en  <= 8'hFF;
      disp_dp  <= '0;
      disp_lz  <= 1'b0;
      an       <= 8'hFF;
      seg      <= 8'hFF;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      // A load coinciding with a commit lands in the shadow after the old shadow was copied.
      pending  <= load | (pending & ~commit);
      if (load) begin
        sh_val <= value_in;
        sh_en  <= digit_en_in;
        sh_dp  <= dp_in;
        sh_lz  <= lz_in;
      end
      disp_val <= disp_val_n;
      disp_en  <= disp_en_n;
      disp_dp  <= disp_dp_n;
      disp_lz  <= disp_lz_n;
      an       <= an_n;
      seg      <= seg_n;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a cycle-time model (slot/frame arithmetic) predicts every output.
module tb_display_scan_ctrl;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = 8 * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value_in = '0;
  logic [7:0]  digit_en_in = 8'hFF;
  logic [7:0]  dp_in = '0;
  logic        lz_in = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  an, seg;
  logic        pending, ack, frame_tick, state_dbg;

  always #5 clk = ~clk;

  display_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .digit_en_in(digit_en_in),
    .dp_in(dp_in), .lz_in(lz_in), .load(load), .an(an), .seg(seg),
    .pending(pending), .ack(ack), .frame_tick(frame_tick), .state_dbg(state_dbg)
  );

  logic [6:0] glyph_tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int          t = 0;
  logic [31:0] m_val = '0, s_val = '0;
  logic [7:0]  m_en = 8'hFF, m_dp = '0, s_en = 8'hFF, s_dp = '0;
  logic        m_lz = 1'b0, s_lz = 1'b0, m_pend = 1'b0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // Advance one clock and update the model with what that edge did.
  task automatic tick();
    logic commit;
    @(posedge clk);
    if (rst) begin
      t = 0; m_val = '0; m_en = 8'hFF; m_dp = '0; m_lz = 1'b0;
      s_val = '0; s_en = 8'hFF; s_dp = '0; s_lz = 1'b0; m_pend = 1'b0;
    end else begin
      commit = ((t % FR) == FR - 1) && m_pend;
      if (commit) begin m_val = s_val; m_en = s_en; m_dp = s_dp; m_lz = s_lz; end
      if (load) begin s_val = value_in; s_en = digit_en_in; s_dp = dp_in; s_lz = lz_in; end
      m_pend = load || (m_pend && !commit);
      t++;
    end
    #1;
  endtask

  function automatic logic [7:0] exp_an();
    int pos = t % RD;
    int d = (t / RD) % 8;
    logic [31:0] hi = m_val >> (4 * d);
    if (pos < BC) return 8'hFF;
    if (!m_en[d] || (m_lz && d != 0 && hi == 0)) return 8'hFF;
    return ~(8'(1) << d);
  endfunction

  function automatic logic [7:0] exp_seg();
    int pos = t % RD;
    int d = (t / RD) % 8;
    logic [31:0] sh = m_val >> (4 * d);
    if (pos < BC) return 8'hFF;
    return {~m_dp[d], glyph_tbl[sh[3:0]]};
  endfunction

  function automatic logic exp_ft();
    return (t % FR) == FR - 1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp,
                          input logic lz);
    value_in = v; digit_en_in = en; dp_in = dp; lz_in = lz; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; value_in = 32'hDEADBEEF;
    tick(); tick();
    load = 1'b0; rst = 1'b0;
    total_cnt++; if (an !== 8'hFF) $display("FAIL reset_an got %h want ff", an); else pass_cnt++;
    total_cnt++; if (seg !== 8'hFF) $display("FAIL reset_seg got %h want ff", seg); else pass_cnt++;
    total_cnt++; if (pending !== 1'b0) $display("FAIL reset_pending got %b want 0", pending); else pass_cnt++;
    total_cnt++; if (ack !== 1'b0) $display("FAIL reset_ack got %b want 0", ack); else pass_cnt++;
    total_cnt++; if (frame_tick !== 1'b0) $display("FAIL reset_ft got %b want 0", frame_tick); else pass_cnt++;
  endtask

  task automatic test_default_scan();
    do_reset();
    for (int c = 0; c < FR; c++) begin
      total_cnt++;
      if ({an, seg, frame_tick, ack} !== {exp_an(), exp_seg(), exp_ft(), 1'b0})
        $display("FAIL default_scan t=%0d got an=%h seg=%h ft=%b ack=%b want an=%h seg=%h ft=%b ack=0",
                 t, an, seg, frame_tick, ack, exp_an(), exp_seg(), exp_ft());
      else pass_cnt++;
      if (t == 2) begin
        total_cnt++;
        if ({an, seg} !== {8'hFE, 8'b10000001}) $display("FAIL first_drive got %h/%h want fe/81", an, seg);
        else pass_cnt++;
      end
      if (t == 10) begin
        total_cnt++;
        if (an !== 8'hFD) $display("FAIL digit1_an got %h want fd", an); else pass_cnt++;
      end
      if (t == 63) begin
        total_cnt++;
        if (frame_tick !== 1'b1) $display("FAIL frame_tick63 got %b want 1", frame_tick); else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_load_commit();
    do_reset();
    run_to(5);
    set_load(32'h1234ABCD, 8'hFF, 8'h01, 1'b0);
    total_cnt++; if (pending !== 1'b1) $display("FAIL lc_pending got %b want 1", pending); else pass_cnt++;
    run_to(63);
    total_cnt++;
    if ({ack, frame_tick} !== 2'b11) $display("FAIL lc_ack63 got ack=%b ft=%b want 1 1", ack, frame_tick);
    else pass_cnt++;
    tick();
    total_cnt++; if (pending !== 1'b0) $display("FAIL lc_pend_clear got %b want 0", pending); else pass_cnt++;
    run_to(66);
    while (t <= 71) begin
      total_cnt++;
      if ({an, seg} !== {8'hFE, 8'b01000010}) $display("FAIL lc_digit0 t=%0d got %h/%h want fe/42", t, an, seg);
      else pass_cnt++;
      tick();
    end
    run_to(122);
    total_cnt++;
    if ({an, seg} !== {8'h7F, 8'b11001111}) $display("FAIL lc_digit7 got %h/%h want 7f/cf", an, seg);
    else pass_cnt++;
  endtask

  task automatic test_lz();
    do_reset();
    run_to(1);
    set_load(32'h000000A0, 8'hFF, 8'h00, 1'b1);
    while (t < 2 * FR) begin
      total_cnt++;
      if ({an, seg} !== {exp_an(), exp_seg()})
        $display("FAIL lz_model t=%0d got %h/%h want %h/%h", t, an, seg, exp_an(), exp_seg());
      else pass_cnt++;
      if (t == 66 || t == 74) begin
        total_cnt++;
        if ((t == 66 && {an, seg} !== {8'hFE, 8'b10000001}) || (t == 74 && {an, seg} !== {8'hFD, 8'b10001000}))
          $display("FAIL lz_low_digits t=%0d got %h/%h", t, an, seg);
        else pass_cnt++;
      end
      if (t >= FR && (t % RD) >= BC && ((t / RD) % 8) >= 2) begin
        total_cnt++;
        if (an !== 8'hFF) $display("FAIL lz_suppress t=%0d got %h want ff", t, an); else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_to(3);
    set_load(32'h11111111, 8'hFF, 8'h00, 1'b0);
    run_to(63);
    total_cnt++; if (ack !== 1'b1) $display("FAIL b2b_ack63 got %b want 1", ack); else pass_cnt++;
    set_load(32'h22222222, 8'hFF, 8'h00, 1'b0);
    total_cnt++; if (pending !== 1'b1) $display("FAIL b2b_pend got %b want 1", pending); else pass_cnt++;
    run_to(66);
    total_cnt++; if (seg !== 8'b11001111) $display("FAIL b2b_first got %h want cf", seg); else pass_cnt++;
    run_to(127);
    total_cnt++; if (ack !== 1'b1) $display("FAIL b2b_ack127 got %b want 1", ack); else pass_cnt++;
    tick();
    total_cnt++; if (pending !== 1'b0) $display("FAIL b2b_pend_clear got %b want 0", pending); else pass_cnt++;
    run_to(130);
    total_cnt++; if (seg !== 8'b10010010) $display("FAIL b2b_second got %h want 92", seg); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_to(5);
    set_load(32'hCAFE0000, 8'hFF, 8'hFF, 1'b0);
    run_to(40);
    total_cnt++; if (pending !== 1'b1) $display("FAIL rm_pend_before got %b want 1", pending); else pass_cnt++;
    rst = 1'b1; load = 1'b1; value_in = 32'h55555555;
    tick();
    rst = 1'b0; load = 1'b0;
    total_cnt++;
    if ({an, seg, pending} !== {8'hFF, 8'hFF, 1'b0})
      $display("FAIL rm_after got an=%h seg=%h pend=%b want ff ff 0", an, seg, pending);
    else pass_cnt++;
    run_to(FR - 1);
    total_cnt++;
    if ({frame_tick, ack} !== 2'b10) $display("FAIL rm_no_ack got ft=%b ack=%b want 1 0", frame_tick, ack);
    else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        value_in    = $urandom() >> (4 * $urandom_range(0, 8));
        digit_en_in = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom());
        dp_in       = 8'($urandom());
        lz_in       = 1'($urandom_range(0, 1));
        load        = 1'b1;
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
      load = 1'b0; rst = 1'b0;
      total_cnt++;
      if ({an, seg, frame_tick, ack, pending} !== {exp_an(), exp_seg(), exp_ft(), exp_ft() && m_pend, m_pend})
        $display("FAIL rand t=%0d got an=%h seg=%h ft=%b ack=%b pend=%b want an=%h seg=%h ft=%b ack=%b pend=%b",
                 t, an, seg, frame_tick, ack, pending, exp_an(), exp_seg(), exp_ft(),
                 exp_ft() && m_pend, m_pend);
      else pass_cnt++;
      total_cnt++;
      if ($countones(~an) > 1 || (!state_dbg && an !== 8'hFF) || (state_dbg !== ((t % RD) >= BC)))
        $display("FAIL rand_invariant t=%0d an=%h state=%b", t, an, state_dbg);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_default_scan();
    test_load_commit();
    test_lz();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
